// File: rtl/shift_sequencer.sv
// Two-requester front end for the 8-bit barrel shifter: round-robin grant, multi-pass
// shifting of 0..31 positions (at most 7 per cycle), valid/ready tagged response.

module barrel_shifter (
    input  logic [7:0] din,
    input  logic [2:0] amt,
    input  logic       l_r,
    input  logic       a_l,
    output logic [7:0] dout
);
    always_comb begin
        if (l_r)
            dout = din << amt;
        else if (a_l)
            dout = $signed(din) >>> amt;
        else
            dout = din >> amt;
    end
endmodule

module shift_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [7:0] req0_din,
    input  logic [7:0] req1_din,
    input  logic [4:0] req0_shamt,
    input  logic [4:0] req1_shamt,
    input  logic       req0_l_r,
    input  logic       req1_l_r,
    input  logic       req0_a_l,
    input  logic       req1_a_l,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_data,
    output logic       resp_id
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t     state, state_nxt;
    logic       ptr;
    logic [7:0] work;
    logic [4:0] rem;
    logic       l_r_q, a_l_q, id_q;
    logic       grant_any, grant_id;
    logic [2:0] step;
    logic [4:0] rem_nxt;
    logic [7:0] shift_out;

    // Reset is folded in so no grant is advertised while the block is held in reset.
    assign grant_any = rst_n && (state == IDLE) && (req_valid != 2'b00);

    always_comb begin
        case (req_valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            default: grant_id = ptr;
        endcase
    end

    assign step    = (rem > 5'd7) ? 3'd7 : rem[2:0];
    assign rem_nxt = rem - {2'b00, step};

    barrel_shifter u_shifter (
        .din  (work),
        .amt  (step),
        .l_r  (l_r_q),
        .a_l  (a_l_q),
        .dout (shift_out)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: each combinational output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = BUSY;
            BUSY:    if (rem_nxt == 5'd0) state_nxt = DONE;
            DONE:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= 1'b0;
            work  <= 8'h00;
            rem   <= 5'd0;
            l_r_q <= 1'b0;
            a_l_q <= 1'b0;
            id_q  <= 1'b0;
        end else if (grant_any) begin
            work  <= grant_id ? req1_din   : req0_din;
            rem   <= grant_id ? req1_shamt : req0_shamt;
            l_r_q <= grant_id ? req1_l_r   : req0_l_r;
            a_l_q <= grant_id ? req1_a_l   : req0_a_l;
            id_q  <= grant_id;
            ptr   <= ~grant_id;
        end else if (state == BUSY) begin
            work <= shift_out;
            rem  <= rem_nxt;
        end
    end

    always_comb begin
        req_ready = 2'b00;
        if (grant_any)
            req_ready[grant_id] = 1'b1;
        resp_valid = (state == DONE);
        resp_data  = work;
        resp_id    = id_q;
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: grants push expected results from a plain
// arithmetic model; a negedge monitor checks arbitration, latency, hold and data.

module tb_shift_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_ready;
    logic [7:0] din0 = 8'h00, din1 = 8'h00;
    logic [4:0] sh0 = 5'd0, sh1 = 5'd0;
    logic       lr0 = 1'b0, lr1 = 1'b0, al0 = 1'b0, al1 = 1'b0;
    logic       resp_valid;
    logic       resp_ready = 1'b1;
    logic [7:0] resp_data;
    logic       resp_id;

    shift_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_din   (din0),
        .req1_din   (din1),
        .req0_shamt (sh0),
        .req1_shamt (sh1),
        .req0_l_r   (lr0),
        .req1_l_r   (lr1),
        .req0_a_l   (al0),
        .req1_a_l   (al1),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       id;
        logic [7:0] data;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    logic       grant_log[$];
    int         n_cmp = 0, n_fail = 0;
    int         cyc = 0;
    int         grant_cyc = 0, grant_cnt = 0, resp_cnt = 0;
    logic       inflight = 1'b0, ptr_m = 1'b0, seen_valid = 1'b0;
    logic [7:0] held_data = 8'h00, last_data = 8'h00;
    logic       held_id = 1'b0, last_id = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Full-range shift computed in one step on a 32-bit integer.
    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int amt,
                                             input logic left, input logic arith);
        int v;
        int sv;
        if (left)
            v = (amt >= 8) ? 0 : (int'(d) << amt);
        else if (arith) begin
            sv = d[7] ? (int'(d) - 256) : int'(d);
            v  = sv >>> amt;
        end else
            v = int'(d) >> amt;
        return v[7:0];
    endfunction

    always @(negedge clk) begin
        logic [1:0] exp_rdy;
        logic       gid;
        int         s, p;
        exp_t       e;
        if (rst_n) begin
            exp_rdy = 2'b00;
            if (!inflight) begin
                case (req_valid)
                    2'b01:   exp_rdy = 2'b01;
                    2'b10:   exp_rdy = 2'b10;
                    2'b11:   exp_rdy = ptr_m ? 2'b10 : 2'b01;
                    default: exp_rdy = 2'b00;
                endcase
            end
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            if (req_ready == 2'b01 || req_ready == 2'b10) begin
                gid    = req_ready[1];
                s      = int'(gid ? sh1 : sh0);
                p      = (s + 6) / 7;
                if (p < 1) p = 1;
                e.id   = gid;
                e.data = ref_shift(gid ? din1 : din0, s, gid ? lr1 : lr0, gid ? al1 : al0);
                e.lat  = p + 1;
                sb.push_back(e);
                grant_log.push_back(gid);
                inflight  = 1'b1;
                ptr_m     = ~gid;
                grant_cyc = cyc;
                grant_cnt++;
            end
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check("resp_valid_without_request", 32'(resp_valid), 32'd0);
                end else begin
                    if (!seen_valid) begin
                        check("latency", 32'(cyc - grant_cyc), 32'(sb[0].lat));
                        seen_valid = 1'b1;
                        held_data  = resp_data;
                        held_id    = resp_id;
                    end else begin
                        check("hold_data", 32'(resp_data), 32'(held_data));
                        check("hold_id", 32'(resp_id), 32'(held_id));
                    end
                    if (resp_ready) begin
                        check("resp_data", 32'(resp_data), 32'(sb[0].data));
                        check("resp_id", 32'(resp_id), 32'(sb[0].id));
                        last_data = resp_data;
                        last_id   = resp_id;
                        void'(sb.pop_front());
                        seen_valid = 1'b0;
                        inflight   = 1'b0;
                        resp_cnt++;
                    end
                end
            end else if (seen_valid) begin
                check("resp_valid_dropped", 32'(resp_valid), 32'd1);
                seen_valid = 1'b0;
            end
        end
    end

    task automatic clear_model();
        sb.delete();
        grant_log.delete();
        inflight   = 1'b0;
        ptr_m      = 1'b0;
        seen_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, " resp_data"}, 32'(resp_data), 32'h00);
        check({tag, " resp_id"}, 32'(resp_id), 32'd0);
        check({tag, " req_ready"}, 32'(req_ready), 32'd0);
    endtask

    task automatic rand_fields();
        din0 = 8'($urandom); din1 = 8'($urandom);
        sh0  = 5'($urandom); sh1  = 5'($urandom);
        lr0  = 1'($urandom); lr1  = 1'($urandom);
        al0  = 1'($urandom); al1  = 1'($urandom);
    endtask

    task automatic drive_req(input logic id, input logic [7:0] d, input logic [4:0] s,
                             input logic lr, input logic al);
        if (id) begin
            din1 = d; sh1 = s; lr1 = lr; al1 = al; req_valid = 2'b10;
        end else begin
            din0 = d; sh0 = s; lr0 = lr; al0 = al; req_valid = 2'b01;
        end
    endtask

    task automatic wait_grant(input string tag);
        int g0 = grant_cnt;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            if (grant_cnt != g0) break;
        end
        check({tag, " grant_seen"}, 32'(grant_cnt != g0), 32'd1);
        #1 req_valid = 2'b00;
    endtask

    task automatic wait_resp(input string tag);
        int r0 = resp_cnt;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            if (resp_cnt != r0) break;
        end
        check({tag, " resp_seen"}, 32'(resp_cnt != r0), 32'd1);
        #1;
    endtask

    task automatic drain();
        req_valid  = 2'b00;
        resp_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            if (!inflight) break;
        end
        check("drain_idle", 32'(inflight), 32'd0);
        #1;
    endtask

    task automatic directed(input string tag, input logic id, input logic [7:0] d,
                            input logic [4:0] s, input logic lr, input logic al,
                            input logic [7:0] exp_data);
        resp_ready = 1'b1;
        drive_req(id, d, s, lr, al);
        wait_grant(tag);
        wait_resp(tag);
        check({tag, " data"}, 32'(last_data), 32'(exp_data));
        check({tag, " id"}, 32'(last_id), 32'(id));
    endtask

    task automatic apply_reset(input string tag);
        @(posedge clk);
        #1 rst_n = 1'b0;
        clear_model();
        #1 check_reset_outputs(tag);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with random inputs.
        for (int k = 0; k < 3; k++) begin
            rand_fields();
            req_valid  = 2'($urandom);
            resp_ready = 1'($urandom);
            @(negedge clk);
            check_reset_outputs("in_reset");
            @(posedge clk);
            #1;
        end
        req_valid  = 2'b00;
        resp_ready = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("idle_after_reset resp_valid", 32'(resp_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        directed("single_left", 1'b0, 8'h81, 5'd1,  1'b1, 1'b0, 8'h02);
        directed("arith_neg20", 1'b1, 8'h80, 5'd20, 1'b0, 1'b1, 8'hFF);
        directed("arith_pos20", 1'b1, 8'h7F, 5'd20, 1'b0, 1'b1, 8'h00);
        directed("logic_31",    1'b0, 8'hF0, 5'd31, 1'b0, 1'b0, 8'h00);
        directed("logic_9",     1'b0, 8'hB4, 5'd9,  1'b0, 1'b0, 8'h00);
        directed("logic_3",     1'b1, 8'hB4, 5'd3,  1'b0, 1'b0, 8'h16);

        // Contention from reset: grants must alternate starting at requester 0.
        apply_reset("pre_contention");
        resp_ready = 1'b1;
        rand_fields();
        req_valid = 2'b11;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            if (grant_log.size() >= 4) break;
        end
        #1 req_valid = 2'b00;
        check("contention grants", 32'(grant_log.size() >= 4), 32'd1);
        if (grant_log.size() >= 4) begin
            check("contention grant0", 32'(grant_log[0]), 32'd0);
            check("contention grant1", 32'(grant_log[1]), 32'd1);
            check("contention grant2", 32'(grant_log[2]), 32'd0);
            check("contention grant3", 32'(grant_log[3]), 32'd1);
        end
        drain();

        // Backpressure in DONE with both requesters pushing.
        resp_ready = 1'b0;
        drive_req(1'b1, 8'($urandom), 5'd10, 1'b0, 1'b1);
        wait_grant("backpressure");
        rand_fields();
        req_valid = 2'b11;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (resp_valid) break;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp resp_valid", 32'(resp_valid), 32'd1);
            check("bp req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        wait_resp("backpressure");
        drain();

        // Reset mid-BUSY of a long request.
        drive_req(1'b0, 8'($urandom), 5'd31, 1'b0, 1'b0);
        wait_grant("mid_reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        clear_model();
        #1 check_reset_outputs("mid_busy_reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("no_stale_resp", 32'(resp_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Random traffic with random backpressure.
        for (int k = 0; k < 400; k++) begin
            rand_fields();
            req_valid  = 2'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        drain();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

- Two-requester front end for the team's 8-bit combinational barrel shifter. The shifter takes a 3-bit amount plus left/right and arithmetic/logical selects.
- Extends the shift range to 0..31 by iterating the shifter over multiple cycles, at most 7 positions per pass.
- Shares the single shifter between two requesters under round-robin arbitration.
- Returns results over a valid/ready response channel tagged with the requester ID.

## Interface
Parameters: none (8-bit data, 5-bit amount, two requesters are fixed).

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  2  bit i: requester i presents a request
- req_ready  out  2  bit i: request i accepted this cycle (one-hot or zero)
- req0_din / req1_din  in  8  operand
- req0_shamt / req1_shamt  in  5  shift amount, 0..31
- req0_l_r / req1_l_r  in  1  1 = left, 0 = right
- req0_a_l / req1_a_l  in  1  1 = arithmetic (right only), 0 = logical; ignored for left
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_data  out  8  shifted result
- resp_id  out  1  requester that issued the result

## Operation
- FSM states: IDLE, BUSY, DONE. Only one request in flight.
- IDLE:
  - If any req_valid is set, grant one requester. req_ready is asserted combinationally for the granted requester only.
  - On the grant edge, latch din into work, shamt into rem, and latch l_r, a_l and id. Go to BUSY.
- Arbitration: priority pointer ptr, reset 0.
  - Only one valid: grant it.
  - Both valid: grant the requester indexed by ptr.
  - After any grant, ptr <= ~granted id.
- BUSY, one pass per cycle:
  - step = min(rem, 7).
  - work <= shift(work, step, l_r, a_l).
  - rem <= rem − step.
  - When rem − step == 0, go to DONE.
  - shamt = 0 still spends one BUSY cycle with step 0; data is unchanged.
- Shift semantics:
  - Left: zero fill.
  - Right logical: zero fill.
  - Right arithmetic: fill with work[7].
  - Amounts ≥ 8 saturate naturally: left and logical give 0x00; arithmetic gives 0x00 or 0xFF by sign.
- DONE:
  - resp_valid = 1; resp_data = work; resp_id = latched id.
  - On resp_valid && resp_ready, go to IDLE.
  - req_ready stays 0 in BUSY and DONE; there is no same-cycle turnaround into a new grant.
- The shifter is instantiated once, driven only from work / step / l_r / a_l.

## Timing
- Reset (async, rst_n = 0):
  - state = IDLE, ptr = 0, work = 0, rem = 0, id = 0.
  - Outputs: resp_valid = 0, resp_data = 0x00, resp_id = 0, req_ready = 0.
- Latency from the accept edge to resp_valid rising is P + 1 cycles, where P = max(1, ceil(shamt/7)). Examples: shamt 0..7 → 2 cycles; 31 → 6 cycles.
- resp_valid, resp_data and resp_id hold stable until the handshake; resp_ready may be held low indefinitely.
- Earliest next grant is the cycle after the response handshake. Throughput is 1 request per P + 2 cycles.
- Requester inputs are sampled only on the grant edge; later changes have no effect.
- Requester fields are don't-care when req_valid is low.
- A requester dropping req_valid before grant is legal; no grant is issued to it.
- Reset asserted mid-BUSY or mid-DONE aborts the operation:
  - The result is lost and no response is produced.
  - resp_valid falls immediately (asynchronously).

## Test plan
- Reset: hold rst_n = 0 with random inputs.
  - Required: resp_valid = 0, resp_data = 0x00, resp_id = 0, req_ready = 0.
  - After release with no valid, the block stays idle.
- Single left: req0 din = 0x81, shamt = 1, l_r = 1.
  - Required: req_ready = 01 for one cycle; resp_valid exactly 2 cycles after accept.
  - Response: resp_data = 0x02, resp_id = 0.
- Multi-pass arithmetic: req1 din = 0x80, shamt = 20, l_r = 0, a_l = 1.
  - Required: 3 BUSY cycles, resp_valid 4 cycles after accept.
  - Response: resp_data = 0xFF, resp_id = 1.
  - Repeat with din = 0x7F: resp_data = 0x00.
- Max amount logical: din = 0xF0, shamt = 31, right logical.
  - Required: 5 BUSY cycles; resp_data = 0x00.
  - Also din = 0xB4, shamt = 9, right logical: 2 passes (7, 2); resp_data = 0x00.
  - Also din = 0xB4, shamt = 3: resp_data = 0x16.
- Contention: req_valid = 11 held continuously with resp_ready = 1.
  - Required grant order from reset: 0, 1, 0, 1.
  - req_ready is never 11; resp_id sequence matches the grant order.
- Backpressure and reset mid-op:
  - Hold resp_ready = 0 for 5 cycles in DONE. Required: resp_data and resp_id stable, req_ready stays 00. Then handshake.
  - Next, assert rst_n = 0 during BUSY of a shamt = 31 request. Required: immediate return to the reset values and no stale response after release.
